// File: rtl/operand_frame_loader_pkg.sv
// Shared constants and types for the operand frame loader: operand slots,
// loader states and error codes.
package operand_frame_loader_pkg;

    localparam int NUM_OPS = 8;
    localparam int IDX_W   = 3;

    localparam int OP_X = 0;
    localparam int OP_Y = 1;
    localparam int OP_Z = 2;
    localparam int OP_P = 3;
    localparam int OP_Q = 4;
    localparam int OP_R = 5;
    localparam int OP_S = 6;
    localparam int OP_T = 7;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OPS - 1);

    typedef enum logic {
        LOAD = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam logic [1:0] ERR_NONE   = 2'b00;
    localparam logic [1:0] ERR_SHORT  = 2'b01;
    localparam logic [1:0] ERR_NOLAST = 2'b10;

endpackage

// File: rtl/operand_frame_loader_if.sv
// Word stream in, frame out, plus error and frame-count status.
// slave is the loader's view, master is the producer/consumer side.
interface operand_frame_loader_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic             frame_valid;
    logic             frame_ready;
    logic [WIDTH-1:0] X, Y, Z, P, Q, R, S, T;
    logic             err_valid;
    logic [1:0]       err_code;
    logic [CNT_W-1:0] frame_cnt;

    modport slave (
        input  in_valid, in_data, in_last, frame_ready,
        output in_ready, frame_valid, X, Y, Z, P, Q, R, S, T,
               err_valid, err_code, frame_cnt
    );

    modport master (
        output in_valid, in_data, in_last, frame_ready,
        input  in_ready, frame_valid, X, Y, Z, P, Q, R, S, T,
               err_valid, err_code, frame_cnt
    );
endinterface

// File: rtl/operand_frame_loader_bank.sv
// Eight-slot operand register bank with per-slot write and a whole-bank
// parallel load; the parallel load wins when both are active.
module operand_bank
    import operand_frame_loader_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_OPS-1:0]              we,
    input  logic [WIDTH-1:0]                wdata,
    input  logic                            load,
    input  logic [NUM_OPS-1:0][WIDTH-1:0]   load_data,
    output logic [NUM_OPS-1:0][WIDTH-1:0]   rd
);

    always_ff @(posedge clk) begin
        if (rst) begin
            rd <= '0;
        end else if (load) begin
            rd <= load_data;
        end else begin
            for (int i = 0; i < NUM_OPS; i++) begin
                if (we[i]) rd[i] <= wdata;
            end
        end
    end

endmodule

// File: rtl/operand_frame_loader.sv
// Assembles eight streamed operand words into a frame held on registered
// outputs; a staging bank lets the next frame load while one is presented.
module operand_frame_loader
    import operand_frame_loader_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    operand_frame_loader_if.slave bus
);

    state_t                          state;
    logic [IDX_W-1:0]                idx;
    logic                            frame_valid;
    logic                            err_valid;
    logic [1:0]                      err_code;
    logic [CNT_W-1:0]                frame_cnt;

    logic                            in_ready;
    logic                            accept;
    logic                            at_last;
    logic                            out_free;
    logic                            transfer;
    logic [NUM_OPS-1:0]              stg_we;
    logic [NUM_OPS-1:0][WIDTH-1:0]   stg_rd;
    logic [NUM_OPS-1:0][WIDTH-1:0]   out_rd;
    logic [NUM_OPS-1:0][WIDTH-1:0]   load_data;

    assign in_ready = (state == LOAD);
    assign accept   = bus.in_valid && in_ready;
    assign at_last  = (idx == LAST_IDX);
    assign out_free = !frame_valid || bus.frame_ready;
    assign transfer = (state == LOAD && accept && at_last && out_free) ||
                      (state == HOLD && out_free);

    always_comb begin
        stg_we = '0;
        if (accept) stg_we[idx] = 1'b1;
    end

    // In LOAD the 8th word bypasses staging straight into the output bank.
    always_comb begin
        load_data = stg_rd;
        if (state == LOAD) load_data[LAST_IDX] = bus.in_data;
    end

    operand_bank #(.WIDTH(WIDTH)) u_staging (
        .clk       (clk),
        .rst       (rst),
        .we        (stg_we),
        .wdata     (bus.in_data),
        .load      (1'b0),
        .load_data ('0),
        .rd        (stg_rd)
    );

    operand_bank #(.WIDTH(WIDTH)) u_output (
        .clk       (clk),
        .rst       (rst),
        .we        ('0),
        .wdata     ('0),
        .load      (transfer),
        .load_data (load_data),
        .rd        (out_rd)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= LOAD;
            idx         <= '0;
            frame_valid <= 1'b0;
            err_valid   <= 1'b0;
            err_code    <= ERR_NONE;
            frame_cnt   <= '0;
        end else begin
            err_valid <= 1'b0;
            if (frame_valid && bus.frame_ready) frame_cnt <= frame_cnt + CNT_W'(1);

            if (transfer) begin
                frame_valid <= 1'b1;
            end else if (frame_valid && bus.frame_ready) begin
                frame_valid <= 1'b0;
            end

            case (state)
                LOAD: begin
                    if (accept) begin
                        if (at_last) begin
                            idx <= '0;
                            if (!out_free) state <= HOLD;
                            if (!bus.in_last) begin
                                err_valid <= 1'b1;
                                err_code  <= ERR_NOLAST;
                            end
                        end else if (bus.in_last) begin
                            idx       <= '0;
                            err_valid <= 1'b1;
                            err_code  <= ERR_SHORT;
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end
                end
                HOLD: begin
                    if (out_free) state <= LOAD;
                end
                default: state <= LOAD;
            endcase
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.frame_valid = frame_valid;
    assign bus.err_valid   = err_valid;
    assign bus.err_code    = err_code;
    assign bus.frame_cnt   = frame_cnt;
    assign bus.X = out_rd[OP_X];
    assign bus.Y = out_rd[OP_Y];
    assign bus.Z = out_rd[OP_Z];
    assign bus.P = out_rd[OP_P];
    assign bus.Q = out_rd[OP_Q];
    assign bus.R = out_rd[OP_R];
    assign bus.S = out_rd[OP_S];
    assign bus.T = out_rd[OP_T];

endmodule

// File: tb/tb_operand_frame_loader.sv
// Scoreboard bench for operand_frame_loader: directed frames push expected
// frames/errors, a negedge monitor pops and compares on every handshake or error pulse.
module tb_operand_frame_loader;

    localparam int WIDTH   = 32;
    localparam int CNT_W   = 16;
    localparam int TIMEOUT = 200;

    typedef logic [7:0][31:0] frame_t;

    logic clk;
    logic rst;
    int   tests;
    int   fails;
    int   exp_cnt;

    frame_t     exp_frames[$];
    logic [1:0] exp_errs[$];

    operand_frame_loader_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    operand_frame_loader #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic frame_t make_frame(input logic [31:0] start);
        frame_t f;
        for (int i = 0; i < 8; i++) f[i] = start + 32'(i);
        return f;
    endfunction

    // Monitor: compares presented frames at handshake and every error pulse.
    always @(negedge clk) begin
        frame_t f;
        frame_t act;
        logic [1:0] e;
        if (rst) begin
            exp_cnt = 0;
        end else begin
            if (bus.frame_valid && bus.frame_ready) begin
                if (exp_frames.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_frame actual=%0h expected=none", bus.X);
                end else begin
                    f = exp_frames.pop_front();
                    act = {bus.T, bus.S, bus.R, bus.Q, bus.P, bus.Z, bus.Y, bus.X};
                    for (int i = 0; i < 8; i++)
                        check($sformatf("frame_op%0d", i), act[i], f[i]);
                    check("frame_cnt_at_handshake", 32'(bus.frame_cnt), 32'(exp_cnt[CNT_W-1:0]));
                end
                exp_cnt++;
            end
            if (bus.err_valid) begin
                if (exp_errs.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_err actual=%0h expected=none", bus.err_code);
                end else begin
                    e = exp_errs.pop_front();
                    check("err_code", 32'(bus.err_code), 32'(e));
                end
            end
        end
    end

    task automatic send_word(input logic [31:0] d, input logic last, output int stall);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = last;
        @(negedge clk);
        while (!bus.in_ready && n < TIMEOUT) begin
            n++;
            @(negedge clk);
        end
        if (n >= TIMEOUT) begin
            tests++;
            fails++;
            $display("FAIL in_ready_timeout actual=0 expected=1");
        end
        stall = n;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic send_frame(input frame_t f, input logic last8, output int stalls);
        int s;
        stalls = 0;
        exp_frames.push_back(f);
        for (int i = 0; i < 8; i++) begin
            send_word(f[i], (i == 7) ? last8 : 1'b0, s);
            stalls += s;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int st;
        int s;
        tests = 0;
        fails = 0;
        exp_cnt = 0;
        rst = 1'b1;
        bus.in_valid    = 1'b0;
        bus.in_data     = '0;
        bus.in_last     = 1'b0;
        bus.frame_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        check("rst_frame_valid", 32'(bus.frame_valid), 32'd0);
        check("rst_X", bus.X, 32'd0);
        check("rst_T", bus.T, 32'd0);
        check("rst_err_valid", 32'(bus.err_valid), 32'd0);
        check("rst_frame_cnt", 32'(bus.frame_cnt), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        rst = 1'b0;

        // Single frame 1..8
        bus.frame_ready = 1'b1;
        send_frame(make_frame(32'd1), 1'b1, st);
        check("latency_frame_valid", 32'(bus.frame_valid), 32'd1);
        wait_cycles(1);
        check("t1_frame_valid_cleared", 32'(bus.frame_valid), 32'd0);
        check("t1_frame_cnt", 32'(bus.frame_cnt), 32'd1);
        check("t1_X_held", bus.X, 32'd1);

        // Back-to-back 1..8, 9..16 from a fresh reset
        do_reset();
        send_frame(make_frame(32'd1), 1'b1, st);
        send_frame(make_frame(32'd9), 1'b1, s);
        check("b2b_stalls", 32'(st + s), 32'd0);
        wait_cycles(2);
        check("b2b_frame_cnt", 32'(bus.frame_cnt), 32'd2);
        check("b2b_X", bus.X, 32'd9);
        check("b2b_T", bus.T, 32'd16);

        // Backpressure: A held, B staged, loader in HOLD
        bus.frame_ready = 1'b0;
        send_frame(make_frame(32'd1), 1'b1, st);
        send_frame(make_frame(32'd11), 1'b1, st);
        check("hold_in_ready", 32'(bus.in_ready), 32'd0);
        check("hold_X", bus.X, 32'd1);
        check("hold_frame_valid", 32'(bus.frame_valid), 32'd1);
        wait_cycles(3);
        check("hold_in_ready_later", 32'(bus.in_ready), 32'd0);
        check("hold_T_later", bus.T, 32'd8);
        bus.frame_ready = 1'b1;
        wait_cycles(1);
        check("release_X", bus.X, 32'd11);
        check("release_T", bus.T, 32'd18);
        check("release_in_ready", 32'(bus.in_ready), 32'd1);
        check("release_frame_valid", 32'(bus.frame_valid), 32'd1);
        check("release_frame_cnt", 32'(bus.frame_cnt), 32'd3);
        wait_cycles(1);

        // Short frame 5,6,7
        exp_errs.push_back(2'b01);
        send_word(32'd5, 1'b0, s);
        send_word(32'd6, 1'b0, s);
        send_word(32'd7, 1'b1, s);
        check("short_err_valid", 32'(bus.err_valid), 32'd1);
        check("short_err_code", 32'(bus.err_code), 32'd1);
        check("short_no_frame", 32'(bus.frame_valid), 32'd0);
        send_frame(make_frame(32'd21), 1'b1, st);
        check("after_short_X", bus.X, 32'd21);
        wait_cycles(1);

        // Missing last on word 8
        exp_errs.push_back(2'b10);
        send_frame(make_frame(32'd41), 1'b0, st);
        check("nolast_err_valid", 32'(bus.err_valid), 32'd1);
        check("nolast_err_code", 32'(bus.err_code), 32'd2);
        check("nolast_frame_valid", 32'(bus.frame_valid), 32'd1);
        wait_cycles(1);

        // Reset after 4 words
        for (int i = 0; i < 4; i++) send_word(32'd51 + 32'(i), 1'b0, s);
        rst = 1'b1;
        wait_cycles(1);
        check("midrst_frame_valid", 32'(bus.frame_valid), 32'd0);
        check("midrst_X", bus.X, 32'd0);
        check("midrst_T", bus.T, 32'd0);
        check("midrst_frame_cnt", 32'(bus.frame_cnt), 32'd0);
        check("midrst_err_valid", 32'(bus.err_valid), 32'd0);
        rst = 1'b0;
        send_frame(make_frame(32'd61), 1'b1, st);
        check("postrst_X", bus.X, 32'd61);
        check("postrst_T", bus.T, 32'd68);
        wait_cycles(3);
        check("postrst_frame_cnt", 32'(bus.frame_cnt), 32'd1);

        check("frames_left", 32'(exp_frames.size()), 32'd0);
        check("errs_left", 32'(exp_errs.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/operand_frame_loader.md
# operand_frame_loader

Upstream feeder for the six-output shared-subexpression arithmetic block. Receives 32-bit operands one word per handshake on a valid/ready stream, assembles them into an eight-operand frame (X, Y, Z, P, Q, R, S, T in that order) and presents the frame on parallel registered outputs with a frame-level valid/ready handshake. The arithmetic block consumes those outputs combinationally. A staging bank allows the next frame to load while the current frame is still held.

## Interface
- WIDTH, 32, operand width in bits
- CNT_W, 16, frame counter width
- clk  in  1  single clock, rising edge
- rst  in  1  reset; synchronous, active-high
- in_valid  in  1  input word valid
- in_ready  out  1  loader accepts a word this cycle
- in_data  in  WIDTH  operand word
- in_last  in  1  marks the final word of a frame
- frame_valid  out  1  X..T hold a complete frame
- frame_ready  in  1  consumer takes the frame this cycle
- X, Y, Z, P, Q, R, S, T  out  WIDTH each  presented operands, registered
- err_valid  out  1  one-cycle error pulse
- err_code  out  2  01 short frame, 10 missing last; valid only with err_valid
- frame_cnt  out  CNT_W  count of frames handed off

## Operation
- Word accepted when in_valid && in_ready. Index idx (0..7) selects the operand: 0=X, 1=Y, 2=Z, 3=P, 4=Q, 5=R, 6=S, 7=T.
- State LOAD: in_ready=1. Words 0..6 are written to the staging bank; idx increments.
- Accept at idx=7, output bank free (!frame_valid || frame_ready): the output bank loads staging[0..6] plus the current in_data at this edge. frame_valid=1 next cycle, idx returns to 0, state stays LOAD.
- Accept at idx=7, output bank busy: word stored to staging[7], go to HOLD.
- HOLD: in_ready=0. When !frame_valid || frame_ready, transfer staging to the output bank, frame_valid stays or becomes 1, go to LOAD with idx=0.
- Output handshake: frame_valid && frame_ready with no transfer at the same edge clears frame_valid. X..T keep their last value after the handshake; they change only on transfer.
- Short frame (in_last on an accepted word with idx<7): drop the partial frame, set idx=0, err_valid=1 with err_code=01 next cycle. No frame is produced.
- Missing last (accepted word at idx=7 with in_last=0): frame processed normally, err_valid=1 with err_code=10 next cycle.
- frame_cnt increments on each frame_valid && frame_ready. It wraps from 2^CNT_W-1 to 0.
- Reset: state LOAD, idx=0, frame_valid=0, X..T=0, err_valid=0, err_code=0, frame_cnt=0. A partial frame is discarded.
- Reset asserted mid-frame or mid-HOLD overrides everything at that edge. Nothing is presented, and no error is reported.

## Timing
- Latency: frame_valid rises one cycle after the 8th word is accepted.
- Throughput: with frame_ready held high, one frame per 8 accepted words and no input bubbles.
- in_ready depends only on state (registered-decode), never combinationally on frame_ready.
- HOLD exit: transfer happens at the edge where frame_ready=1 is sampled. in_ready=1 from the following cycle.
- Simultaneous output handshake and transfer at one edge: frame_valid stays 1, new operands appear, frame_cnt increments once.
- err_valid is a single-cycle registered pulse. Back-to-back errors produce back-to-back pulses.

## Structure
- Shared package:
  - operand index constants OP_X..OP_T (0..7)
  - state enum {LOAD, HOLD}
  - err codes ERR_NONE=00, ERR_SHORT=01, ERR_NOLAST=10
  - NUM_OPS=8
- One sub-module, operand_bank: an 8×WIDTH register bank.
  - Ports: per-index write enable and parallel read.
  - Instantiated twice, as staging bank and output bank.
  - The output bank has a parallel load from staging.

## Test plan
- Reset, then words 1..8 with in_last on the 8th, frame_ready=1. Expected:
  - frame_valid=1 one cycle after word 8
  - X=1, Y=2, Z=3, P=4, Q=5, R=6, S=7, T=8
  - frame_cnt=1 after the handshake
- Two frames back-to-back (1..8, then 9..16), frame_ready=1: no in_ready deassertion; the second frame shows X=9…T=16; frame_cnt=2.
- Backpressure:
  - Frame A (1..8) presented with frame_ready=0; frame B (11..18) loaded.
  - Expected: HOLD, in_ready=0, X stays 1.
  - Raise frame_ready: the next cycle shows X=11, T=18, and in_ready returns to 1.
- Words 5, 6, 7 with in_last on word 7: err_valid pulse with err_code=01, no frame_valid. The following 8-word frame loads from X.
- 8 words with in_last=0 on word 8: frame presented, err_valid with err_code=10 in the same cycle as frame_valid rises.
- rst asserted after 4 words: all outputs 0, frame_valid=0, frame_cnt=0. The next 8 words form a correct frame starting at X.
